// File: rtl/gray_code_conv_pipe_if.sv
// gray_code_conv_pipe_if
//   Input/output handshake bundle for gray_code_conv_pipe.
//   Upstream side:   in_valid, in_ready, in_mode, in_data
//   Downstream side: out_valid, out_ready, out_mode, out_data
//   Status:          step_err (one-cycle pulse), err_cnt (8-bit saturating)
//   master = the environment around the converter, slave = the converter.
interface gray_code_conv_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [WIDTH-1:0] out_data;
    logic             step_err;
    logic [7:0]       err_cnt;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, step_err, err_cnt
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, step_err, err_cnt
    );
endinterface

// File: rtl/gray_code_conv_pipe.sv
// gray_code_conv_pipe
//   Pipelined bidirectional Gray/binary converter with valid/ready on both
//   sides. Each word carries its own mode (0 = Gray-to-binary, 1 =
//   binary-to-Gray). The Gray-to-binary prefix XOR is split over STAGES
//   registers, MSB chunk first; the last stage register drives the output.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - gray_code_conv_pipe_if.slave (in_* handshake, out_* handshake,
//            step_err pulse, err_cnt saturating counter)
//   Optional feature macro: GRAY_CONV_STEP_CHECK_EN (Gray step checking on
//   consecutive accepted mode-0 words; step_err/err_cnt tied to 0 without it).
module gray_code_conv_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_code_conv_pipe_if.slave  bus
);
    // Bits of the prefix XOR resolved per stage.
    localparam int unsigned CHUNK = (STAGES == 0) ? 1 : (WIDTH + STAGES - 1) / STAGES;

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("gray_code_conv_pipe: WIDTH must be within 2..64");
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_stages_check
        $error("gray_code_conv_pipe: STAGES must be within 1..WIDTH");
    end

    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_mode;
    logic [WIDTH-1:0]  stg_data [STAGES];
    logic [WIDTH-1:0]  nxt_data [STAGES];
    logic              adv;

    // A word in flight holds already-resolved binary bits above the
    // still-Gray bits, so bit i resolves from its resolved neighbour i+1.
    function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] d,
                                                  input int unsigned    stage);
        logic [WIDTH-1:0] r;
        int               hi;
        int               lo;
        r  = d;
        hi = int'(WIDTH) - 1 - int'((stage - 32'd1) * CHUNK);
        lo = int'(WIDTH) - int'(stage * CHUNK);
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                r[i] = r[i+1] ^ r[i];
            end
        end
        return r;
    endfunction

    // Whole pipeline moves together whenever the output slot can drain.
    assign adv          = !stg_valid[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = stg_valid[STAGES-1];
    assign bus.out_mode  = stg_mode[STAGES-1];
    assign bus.out_data  = stg_data[STAGES-1];

    // Per-stage conversion work; mode-1 words are finished in stage 1.
    always_comb begin
        for (int s = 0; s < int'(STAGES); s++) begin
            nxt_data[s] = '0;
        end
        nxt_data[0] = bus.in_mode ? (bus.in_data ^ (bus.in_data >> 1))
                                  : resolve(bus.in_data, 32'd1);
        for (int s = 1; s < int'(STAGES); s++) begin
            nxt_data[s] = stg_mode[s-1] ? stg_data[s-1]
                                        : resolve(stg_data[s-1], 32'(s + 1));
        end
    end

    // Stage registers; payload only loads behind a valid word so data holds
    // across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            stg_mode  <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                stg_data[s] <= '0;
            end
        end else if (adv) begin
            stg_valid[0] <= bus.in_valid;
            if (bus.in_valid) begin
                stg_data[0] <= nxt_data[0];
                stg_mode[0] <= bus.in_mode;
            end
            for (int s = 1; s < int'(STAGES); s++) begin
                stg_valid[s] <= stg_valid[s-1];
                if (stg_valid[s-1]) begin
                    stg_data[s] <= nxt_data[s];
                    stg_mode[s] <= stg_mode[s-1];
                end
            end
        end
    end

`ifdef GRAY_CONV_STEP_CHECK_EN
    logic [WIDTH-1:0]  prev_word;
    logic              prev_ok;
    logic [STAGES-1:0] stg_err;
    logic [7:0]        cnt;
    logic              gray_xfer;
    logic              viol;
    logic              out_xfer_err;

    assign gray_xfer    = bus.in_valid && adv && !bus.in_mode;
    assign viol         = prev_ok && ($countones(bus.in_data ^ prev_word) != 1);
    // Violation flag travels with its word and fires on that word's exit.
    assign out_xfer_err = stg_valid[STAGES-1] && bus.out_ready && stg_err[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_word <= '0;
            prev_ok   <= 1'b0;
            stg_err   <= '0;
            cnt       <= '0;
        end else begin
            if (gray_xfer) begin
                prev_word <= bus.in_data;
                prev_ok   <= 1'b1;
            end
            if (adv) begin
                stg_err[0] <= gray_xfer && viol;
                for (int s = 1; s < int'(STAGES); s++) begin
                    stg_err[s] <= stg_err[s-1];
                end
            end
            if (out_xfer_err && cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign bus.step_err = out_xfer_err;
    assign bus.err_cnt  = cnt;
`else
    assign bus.step_err = 1'b0;
    assign bus.err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_gray_code_conv_pipe.sv
// tb_gray_code_conv_pipe
//   Bench for gray_code_conv_pipe: three instances (STAGES = 2, 1, 8 at
//   WIDTH = 8) sharing clk/rst; directed scenarios on the STAGES=2 instance
//   and random streams on all three against an arithmetic reference model.
module tb_gray_code_conv_pipe;
    localparam int NW = 1000;
`ifdef GRAY_CONV_STEP_CHECK_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic       drv_valid  [3];
    logic       drv_mode   [3];
    logic [7:0] drv_data   [3];
    logic       drv_oready [3];
    logic       obs_in_ready  [3];
    logic       obs_out_valid [3];
    logic       obs_out_mode  [3];
    logic [7:0] obs_out_data  [3];
    logic       obs_step_err  [3];
    logic [7:0] obs_err_cnt   [3];

    gray_code_conv_pipe_if #(.WIDTH(8)) bus0 ();
    gray_code_conv_pipe_if #(.WIDTH(8)) bus1 ();
    gray_code_conv_pipe_if #(.WIDTH(8)) bus2 ();

    gray_code_conv_pipe #(.WIDTH(8), .STAGES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gray_code_conv_pipe #(.WIDTH(8), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    gray_code_conv_pipe #(.WIDTH(8), .STAGES(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus0.in_valid = drv_valid[0];
    assign bus0.in_mode  = drv_mode[0];
    assign bus0.in_data  = drv_data[0];
    assign bus0.out_ready = drv_oready[0];
    assign obs_in_ready[0]  = bus0.in_ready;
    assign obs_out_valid[0] = bus0.out_valid;
    assign obs_out_mode[0]  = bus0.out_mode;
    assign obs_out_data[0]  = bus0.out_data;
    assign obs_step_err[0]  = bus0.step_err;
    assign obs_err_cnt[0]   = bus0.err_cnt;

    assign bus1.in_valid = drv_valid[1];
    assign bus1.in_mode  = drv_mode[1];
    assign bus1.in_data  = drv_data[1];
    assign bus1.out_ready = drv_oready[1];
    assign obs_in_ready[1]  = bus1.in_ready;
    assign obs_out_valid[1] = bus1.out_valid;
    assign obs_out_mode[1]  = bus1.out_mode;
    assign obs_out_data[1]  = bus1.out_data;
    assign obs_step_err[1]  = bus1.step_err;
    assign obs_err_cnt[1]   = bus1.err_cnt;

    assign bus2.in_valid = drv_valid[2];
    assign bus2.in_mode  = drv_mode[2];
    assign bus2.in_data  = drv_data[2];
    assign bus2.out_ready = drv_oready[2];
    assign obs_in_ready[2]  = bus2.in_ready;
    assign obs_out_valid[2] = bus2.out_valid;
    assign obs_out_mode[2]  = bus2.out_mode;
    assign obs_out_data[2]  = bus2.out_data;
    assign obs_step_err[2]  = bus2.step_err;
    assign obs_err_cnt[2]   = bus2.err_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion: binary bit i is the parity of Gray bits i and up.
    function automatic logic [7:0] ref_conv(input logic [7:0] d, input logic m);
        logic [7:0] r;
        if (m) return d ^ (d >> 1);
        for (int i = 0; i < 8; i++) r[i] = ^(d >> i);
        return r;
    endfunction

    // Cycles from input-side negedge sample to output-side negedge sample.
    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            drv_valid[k]  = 1'b0;
            drv_mode[k]   = 1'b0;
            drv_data[k]   = 8'h00;
            drv_oready[k] = 1'b1;
        end
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_out_valid[k] !== 1'b0 || obs_in_ready[k] !== 1'b1 ||
                obs_out_data[k] !== 8'h00 || obs_out_mode[k] !== 1'b0 ||
                obs_step_err[k] !== 1'b0 || obs_err_cnt[k] !== 8'h00)
            begin
                errors++;
                $display("FAIL reset dut%0d: got v=%b rdy=%b d=%h m=%b se=%b cnt=%0d want 0 1 00 0 0 0",
                         k, obs_out_valid[k], obs_in_ready[k], obs_out_data[k],
                         obs_out_mode[k], obs_step_err[k], obs_err_cnt[k]);
            end
        end
    endtask

    // Back-to-back words with mixed modes on the STAGES=2 instance.
    task automatic test_directed();
        logic [7:0] w [5];
        logic       m [5];
        logic [7:0] e [5];
        w = '{8'hC0, 8'hFF, 8'hAA, 8'h07, 8'h05};
        m = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        e = '{8'h80, 8'hAA, 8'hFF, 8'h05, 8'h07};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drv_valid[0] = (k < 5);
            drv_data[0]  = (k < 5) ? w[k] : 8'h00;
            drv_mode[0]  = (k < 5) ? m[k] : 1'b0;
            checks++;
            if (obs_in_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL directed in_ready cyc%0d: got %b want 1", k, obs_in_ready[0]);
            end
            checks++;
            if (k >= 2) begin
                if (obs_out_valid[0] !== 1'b1 || obs_out_data[0] !== e[k-2] ||
                    obs_out_mode[0] !== m[k-2]) begin
                    errors++;
                    $display("FAIL directed word%0d: got v=%b d=%h m=%b want v=1 d=%h m=%b",
                             k - 2, obs_out_valid[0], obs_out_data[0], obs_out_mode[0],
                             e[k-2], m[k-2]);
                end
            end else if (obs_out_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL directed early cyc%0d: got out_valid=%b want 0", k, obs_out_valid[0]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (obs_out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL directed tail: got out_valid=%b want 0", obs_out_valid[0]);
        end
    endtask

    // Fill, freeze with out_ready low, release and drain in order.
    task automatic test_stall();
        logic [7:0] wd [4];
        logic       md [4];
        int tx, rx;
        for (int i = 0; i < 4; i++) begin
            wd[i] = 8'($urandom);
            md[i] = 1'($urandom_range(0, 1));
        end
        do_reset();
        drv_oready[0] = 1'b0;
        drv_valid[0] = 1'b1; drv_data[0] = wd[0]; drv_mode[0] = md[0];
        @(posedge clk); #1;
        drv_data[0] = wd[1]; drv_mode[0] = md[1];
        @(posedge clk); #1;
        drv_data[0] = wd[2]; drv_mode[0] = md[2];
        tx = 2;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_in_ready[0] !== 1'b0 || obs_out_valid[0] !== 1'b1 ||
                obs_out_data[0] !== ref_conv(wd[0], md[0]) || obs_out_mode[0] !== md[0]) begin
                errors++;
                $display("FAIL stall hold cyc%0d: got rdy=%b v=%b d=%h m=%b want 0 1 %h %b",
                         c, obs_in_ready[0], obs_out_valid[0], obs_out_data[0], obs_out_mode[0],
                         ref_conv(wd[0], md[0]), md[0]);
            end
            @(posedge clk); #1;
        end
        drv_oready[0] = 1'b1;
        rx = 0;
        for (int c = 0; c < 20 && rx < 4; c++) begin
            drv_valid[0] = (tx < 4);
            drv_data[0]  = (tx < 4) ? wd[tx] : 8'h00;
            drv_mode[0]  = (tx < 4) ? md[tx] : 1'b0;
            @(negedge clk);
            if (obs_out_valid[0] && drv_oready[0]) begin
                checks++;
                if (obs_out_data[0] !== ref_conv(wd[rx], md[rx]) || obs_out_mode[0] !== md[rx]) begin
                    errors++;
                    $display("FAIL stall drain word%0d: got d=%h m=%b want d=%h m=%b",
                             rx, obs_out_data[0], obs_out_mode[0], ref_conv(wd[rx], md[rx]), md[rx]);
                end
                rx++;
            end
            if (drv_valid[0] && obs_in_ready[0]) tx++;
            @(posedge clk); #1;
        end
        checks++;
        if (rx != 4) begin
            errors++;
            $display("FAIL stall drain count: got %0d words want 4", rx);
        end
        drv_valid[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_out_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall duplicate cyc%0d: got out_valid=%b want 0", c, obs_out_valid[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset with two words in flight; neither may reappear.
    task automatic test_midreset();
        do_reset();
        drv_oready[0] = 1'b0;
        drv_valid[0] = 1'b1; drv_data[0] = 8'h3C; drv_mode[0] = 1'b0;
        @(posedge clk); #1;
        drv_data[0] = 8'h81; drv_mode[0] = 1'b1;
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        drv_oready[0] = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (obs_out_valid[0] !== 1'b0 || obs_err_cnt[0] !== 8'h00 || obs_in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset: got v=%b cnt=%0d rdy=%b want 0 0 1",
                     obs_out_valid[0], obs_err_cnt[0], obs_in_ready[0]);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (obs_out_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL midreset stale cyc%0d: got out_valid=%b want 0", c, obs_out_valid[0]);
            end
        end
    endtask

    // Gray step checker: one violation in a short sequence, then saturation.
    task automatic test_step_check();
        logic [7:0] seq [4];
        int tx, rx, model_cnt;
        logic exp_e;
        seq = '{8'h00, 8'h01, 8'h03, 8'h00};
        do_reset();
        tx = 0; rx = 0; model_cnt = 0;
        for (int c = 0; c < 40 && rx < 4; c++) begin
            drv_valid[0] = (tx < 4);
            drv_data[0]  = (tx < 4) ? seq[tx] : 8'h00;
            drv_mode[0]  = 1'b0;
            @(negedge clk);
            if (obs_out_valid[0] && drv_oready[0]) begin
                exp_e = STEP_EN && (rx > 0) && ($countones(seq[rx] ^ seq[rx-1]) != 1);
                if (exp_e) model_cnt++;
                checks++;
                if (obs_step_err[0] !== exp_e) begin
                    errors++;
                    $display("FAIL step_err word%0d: got %b want %b", rx, obs_step_err[0], exp_e);
                end
                rx++;
            end
            if (drv_valid[0] && obs_in_ready[0]) tx++;
            @(posedge clk); #1;
        end
        drv_valid[0] = 1'b0;
        checks++;
        if (rx != 4) begin
            errors++;
            $display("FAIL step seq count: got %0d words want 4", rx);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_err_cnt[0] !== 8'(model_cnt)) begin
            errors++;
            $display("FAIL err_cnt short: got %0d want %0d", obs_err_cnt[0], model_cnt);
        end
        // 300 repeats of the last word are all distance-0 violations.
        tx = 0; rx = 0;
        for (int c = 0; c < 400 && rx < 300; c++) begin
            drv_valid[0] = (tx < 300);
            drv_data[0]  = 8'h00;
            drv_mode[0]  = 1'b0;
            @(negedge clk);
            if (obs_out_valid[0] && drv_oready[0]) begin
                rx++;
                if (STEP_EN && model_cnt < 255) model_cnt++;
            end
            if (drv_valid[0] && obs_in_ready[0]) tx++;
            @(posedge clk); #1;
        end
        drv_valid[0] = 1'b0;
        checks++;
        if (rx != 300) begin
            errors++;
            $display("FAIL step flood count: got %0d words want 300", rx);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_err_cnt[0] !== 8'(model_cnt) || model_cnt != (STEP_EN ? 255 : 0)) begin
            errors++;
            $display("FAIL err_cnt saturate: got %0d want %0d", obs_err_cnt[0], STEP_EN ? 255 : 0);
        end
    endtask

    logic [8:0] exp_mem [3][NW];
    logic [9:0] hist    [3][16];

    // Random words into all three instances; stall=0 also checks exact latency.
    task automatic test_random_stream(input bit stall);
        int wr [3];
        int rd [3];
        logic       was_stalled [3];
        logic [8:0] held [3];
        logic [9:0] e;
        int cyc;
        bit done;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr[k] = 0; rd[k] = 0; was_stalled[k] = 1'b0; held[k] = '0;
            for (int h = 0; h < 16; h++) hist[k][h] = '0;
        end
        cyc = 0;
        done = 1'b0;
        while (cyc < 8000 && !done) begin
            for (int k = 0; k < 3; k++) begin
                drv_valid[k]  = (wr[k] < NW) && ($urandom_range(0, 3) != 0);
                drv_data[k]   = 8'($urandom);
                drv_mode[k]   = 1'($urandom_range(0, 1));
                drv_oready[k] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (was_stalled[k]) begin
                    checks++;
                    if (obs_out_valid[k] !== 1'b1 || {obs_out_mode[k], obs_out_data[k]} !== held[k]) begin
                        errors++;
                        $display("FAIL rand hold dut%0d cyc%0d: got v=%b %h want v=1 %h",
                                 k, cyc, obs_out_valid[k], {obs_out_mode[k], obs_out_data[k]}, held[k]);
                    end
                end
                if (!stall) begin
                    e = (cyc >= lat_of(k)) ? hist[k][(cyc - lat_of(k)) % 16] : 10'h000;
                    checks++;
                    if (obs_out_valid[k] !== e[9] ||
                        (e[9] && {obs_out_mode[k], obs_out_data[k]} !== e[8:0])) begin
                        errors++;
                        $display("FAIL rand latency dut%0d cyc%0d: got v=%b %h want v=%b %h",
                                 k, cyc, obs_out_valid[k], {obs_out_mode[k], obs_out_data[k]},
                                 e[9], e[8:0]);
                    end
                end
                if (obs_out_valid[k] && drv_oready[k]) begin
                    checks++;
                    if (rd[k] >= wr[k] || {obs_out_mode[k], obs_out_data[k]} !== exp_mem[k][rd[k] % NW]) begin
                        errors++;
                        $display("FAIL rand order dut%0d word%0d: got %h want %h",
                                 k, rd[k], {obs_out_mode[k], obs_out_data[k]}, exp_mem[k][rd[k] % NW]);
                    end
                    rd[k]++;
                end
                hist[k][cyc % 16] = {drv_valid[k] && obs_in_ready[k], drv_mode[k],
                                     ref_conv(drv_data[k], drv_mode[k])};
                if (drv_valid[k] && obs_in_ready[k]) begin
                    exp_mem[k][wr[k]] = {drv_mode[k], ref_conv(drv_data[k], drv_mode[k])};
                    wr[k]++;
                end
                was_stalled[k] = obs_out_valid[k] && !drv_oready[k];
                held[k] = {obs_out_mode[k], obs_out_data[k]};
            end
            done = (rd[0] >= NW) && (rd[1] >= NW) && (rd[2] >= NW);
            cyc++;
            @(posedge clk); #1;
        end
        idle_all();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] != NW || wr[k] != NW) begin
                errors++;
                $display("FAIL rand count dut%0d stall=%0d: got in=%0d out=%0d want %0d",
                         k, stall, wr[k], rd[k], NW);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        idle_all();
        test_reset();
        test_directed();
        test_stall();
        test_midreset();
        test_step_check();
        test_random_stream(1'b0);
        test_random_stream(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gray_code_conv_pipe.md
Name: gray_code_conv_pipe

Overview:
- Parametrised, pipelined, bidirectional Gray/binary code converter with valid/ready handshake on input and output.
- Each accepted word carries its own mode bit: Gray-to-binary or binary-to-Gray.
- The Gray-to-binary prefix-XOR chain is split across STAGES registers so wide words close timing.
- Sits between Gray-coded sources (async FIFO pointers, rotary encoders) and binary consumers; also used in the reverse direction.

Parameters:
- WIDTH, 8, data word width in bits (2..64).
- STAGES, 2, pipeline depth and fixed latency in cycles (1..WIDTH). Any value outside this range is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the word this cycle
- in_mode  in  1  0 = Gray-to-binary, 1 = binary-to-Gray
- in_data  in  WIDTH  input word
- out_valid  out  1  output word present
- out_ready  in  1  downstream accepts the word
- out_mode  out  1  mode of the output word
- out_data  out  WIDTH  converted word
- step_err  out  1  one-cycle Gray step violation pulse (see Optional Feature)
- err_cnt  out  8  saturating step violation count (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits, out_valid, out_data, out_mode, step_err and err_cnt go to 0. in_ready is 1 the cycle after reset.
- Reset mid-operation: every in-flight word is discarded. Nothing is replayed.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational from out_valid and out_ready).
- Stall: the whole pipeline freezes while adv=0. No stage register changes, and out_data/out_mode stay stable while out_valid=1 and out_ready=0.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Both may occur in the same cycle.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+STAGES-1 when no stall occurs. Throughput is 1 word per cycle.
- Bubbles: bubbles propagate; stage valid bits shift with adv. Bubbles are not collapsed.
- Gray-to-binary (mode 0):
  - b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - Stage s (1..STAGES) resolves the next ceil(WIDTH/STAGES) bits, MSB first. The final stage resolves the remainder.
  - The partial result and the unresolved Gray bits are carried between stages.
- Binary-to-Gray (mode 0 = 1): g = b ^ (b >> 1). Computed in stage 1 and carried unchanged through the remaining stages.
- out_mode equals the in_mode captured with the same word. Modes may alternate word to word with no penalty.
- Holding data: out_data holds its last value when out_valid=0. Consumers must not rely on that value.

Optional Feature:
- Macro: GRAY_CONV_STEP_CHECK_EN
- Enabled:
  - On every accepted mode-0 word, compare in_data with the previous accepted mode-0 word.
  - If the Hamming distance is not exactly 1, step_err pulses high for one cycle, aligned with that word's out_valid/out_ready transfer, and err_cnt increments, saturating at 255.
  - A repeated identical word (distance 0) is a violation.
  - The first mode-0 word after reset is not checked.
  - Mode-1 words neither check nor update the stored word.
- Disabled: step_err and err_cnt are tied to 0, and no comparison logic is built.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: mode0 8'hC0 -> 8'h80; mode0 8'hFF -> 8'hAA. Each appears 2 cycles after acceptance, back-to-back with no gaps.
- Mode1 8'hAA -> 8'hFF, then mode1 8'h05 -> 8'h07, interleaved with mode0 8'h07 -> 8'h05. out_mode matches each word.
- Stream 4 words, hold out_ready=0 for 3 cycles with the pipeline full -> in_ready=0, out_data frozen. Release -> all 4 words exit in order, none lost or duplicated.
- Assert rst for 1 cycle with 2 words in flight -> next cycle out_valid=0, err_cnt=0. No stale word ever emerges.
- Sweep STAGES=1 and STAGES=WIDTH=8 with a random 1000-word stream against a reference model -> data and latency match exactly.
- With GRAY_CONV_STEP_CHECK_EN: mode0 sequence 8'h00, 8'h01, 8'h03, 8'h00 -> step_err only on the 4th word, err_cnt=1. With 300 violations -> err_cnt=255.
